// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: 1149.1 state encoding, instruction codes, DR select and pin sample record.
// Imported by the TAP FSM, the TAP top level and the bench.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_t;

  // Kept 32 bits wide; users slice down to their IR width.
  localparam logic [31:0] INSTR_IDCODE = 32'h0000_0001;
  localparam logic [31:0] INSTR_BYPASS = 32'hFFFF_FFFF;
  localparam logic [31:0] INSTR_USER   = 32'h0000_0008;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  typedef struct packed {
    logic vld;
    logic tck;
    logic tms;
    logic tdi;
  } pin_smp_t;

  function automatic logic is_shift(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// JTAG pin bundle between the jtag_b agent (master) and the device TAP (slave).
interface jtag_tap_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine; advances one step per qualified tck rising edge.
// Latency: state changes on the clock edge where tck_rise is high; reset dominates tck_rise.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tck_rise,
  input  logic       tms_s,
  output tap_state_t tap_state
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:        state_d = tms_s ? TLR        : RTI;
        RTI:        state_d = tms_s ? SELECT_DR  : RTI;
        SELECT_DR:  state_d = tms_s ? SELECT_IR  : CAPTURE_DR;
        CAPTURE_DR: state_d = tms_s ? EXIT1_DR   : SHIFT_DR;
        SHIFT_DR:   state_d = tms_s ? EXIT1_DR   : SHIFT_DR;
        EXIT1_DR:   state_d = tms_s ? UPDATE_DR  : PAUSE_DR;
        PAUSE_DR:   state_d = tms_s ? EXIT2_DR   : PAUSE_DR;
        EXIT2_DR:   state_d = tms_s ? UPDATE_DR  : SHIFT_DR;
        UPDATE_DR:  state_d = tms_s ? SELECT_DR  : RTI;
        SELECT_IR:  state_d = tms_s ? TLR        : CAPTURE_IR;
        CAPTURE_IR: state_d = tms_s ? EXIT1_IR   : SHIFT_IR;
        SHIFT_IR:   state_d = tms_s ? EXIT1_IR   : SHIFT_IR;
        EXIT1_IR:   state_d = tms_s ? UPDATE_IR  : PAUSE_IR;
        PAUSE_IR:   state_d = tms_s ? EXIT2_IR   : PAUSE_IR;
        EXIT2_IR:   state_d = tms_s ? UPDATE_IR  : SHIFT_IR;
        UPDATE_IR:  state_d = tms_s ? SELECT_DR  : RTI;
        default:    state_d = TLR;
      endcase
    end
  end

  always_comb begin
    tap_state = state_q;
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Device-side TAP: oversampled tck/tms/tdi, IR plus IDCODE/BYPASS/USER DRs, registered tdo.
// Latency pin edge to action: 1 clock, or 3 with `JTAG_TAP_SYNC_EN` (2-flop synchronizer); no backpressure.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
  input  logic                clock,
  input  logic                reset,
  jtag_tap_if.slave           jtag,
  output tap_state_t          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] user_capture,
  output logic [DR_WIDTH-1:0] user_update,
  output logic                user_update_valid
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = INSTR_IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = INSTR_BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  pin_smp_t pin_now;
  pin_smp_t smp_q;
  logic     tck_prev_q;
  logic     prev_vld_q;
  logic     tck_rise;
  logic     tck_fall;

  always_comb begin
    pin_now     = '0;
    pin_now.vld = 1'b1;
    pin_now.tck = jtag.tck;
    pin_now.tms = jtag.tms;
    pin_now.tdi = jtag.tdi;
  end

`ifdef JTAG_TAP_SYNC_EN
  pin_smp_t sync1_q;
  pin_smp_t sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      smp_q   <= '0;
    end else begin
      sync1_q <= pin_now;
      sync2_q <= sync1_q;
      smp_q   <= sync2_q;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      smp_q <= '0;
    end else begin
      smp_q <= pin_now;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      tck_prev_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      tck_prev_q <= smp_q.tck;
      prev_vld_q <= smp_q.vld;
    end
  end

  // Both compared samples must postdate reset, so a tck held high through reset is not an edge.
  assign tck_rise = smp_q.vld & prev_vld_q &  smp_q.tck & ~tck_prev_q;
  assign tck_fall = smp_q.vld & prev_vld_q & ~smp_q.tck &  tck_prev_q;

  jtag_tap_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .tck_rise  (tck_rise),
    .tms_s     (smp_q.tms),
    .tap_state (tap_state)
  );

  dr_sel_t dr_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (32'(ir_value) == INSTR_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir_value == IR_BYPASS) begin
      dr_sel = DR_BYPASS;
    end else if (32'(ir_value) == INSTR_USER) begin
      dr_sel = DR_USER;
    end
  end

  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic                bypass_sr;
  logic [DR_WIDTH-1:0] user_sr;

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_sr     <= '0;
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      user_sr   <= '0;
    end else if (tck_rise) begin
      unique case (tap_state)
        CAPTURE_IR: ir_sr <= IR_CAPTURE;
        SHIFT_IR:   ir_sr <= {smp_q.tdi, ir_sr[IR_WIDTH-1:1]};
        CAPTURE_DR: begin
          unique case (dr_sel)
            DR_IDCODE: idcode_sr <= IDCODE_VAL;
            DR_USER:   user_sr   <= user_capture;
            default:   bypass_sr <= 1'b0;
          endcase
        end
        SHIFT_DR: begin
          unique case (dr_sel)
            DR_IDCODE: idcode_sr <= {smp_q.tdi, idcode_sr[31:1]};
            DR_USER:   user_sr   <= {smp_q.tdi, user_sr[DR_WIDTH-1:1]};
            default:   bypass_sr <= smp_q.tdi;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_value <= IR_IDCODE;
    end else if (tap_state == TLR) begin
      ir_value <= IR_IDCODE;
    end else if (tck_fall && (tap_state == UPDATE_IR)) begin
      ir_value <= ir_sr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      user_update       <= '0;
      user_update_valid <= 1'b0;
    end else begin
      user_update_valid <= 1'b0;
      if (tck_fall && (tap_state == UPDATE_DR) && (dr_sel == DR_USER)) begin
        user_update       <= user_sr;
        user_update_valid <= 1'b1;
      end
    end
  end

  logic dr_lsb;

  always_comb begin
    unique case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_sr[0];
      DR_USER:   dr_lsb = user_sr[0];
      default:   dr_lsb = bypass_sr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jtag.tdo <= 1'b0;
    end else if (tck_fall) begin
      if (tap_state == SHIFT_IR) begin
        jtag.tdo <= ir_sr[0];
      end else if (tap_state == SHIFT_DR) begin
        jtag.tdo <= dr_lsb;
      end
    end
  end

  always_comb begin
    jtag.tdo_en = is_shift(tap_state);
  end

endmodule
